// File: rtl/armleocpu_decode_pkg.sv
// armleocpu_decode_pkg
// Shared definitions for the decode stage. It holds:
//   - ARMLEOCPU_OPCLASS_* 4-bit operation class codes
//   - ARMLEOCPU_OPCODE_* 7-bit RV32I major opcodes
//   - the canonical NOP instruction (addi x0, x0, 0)
//   - the execute->fetch command codes and their width
//   - the registered d2e bundle type and helpers that build it
package armleocpu_decode_pkg;

  localparam logic [3:0] ARMLEOCPU_OPCLASS_LUI     = 4'd0;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_AUIPC   = 4'd1;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_JAL     = 4'd2;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_JALR    = 4'd3;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_BRANCH  = 4'd4;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_LOAD    = 4'd5;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_STORE   = 4'd6;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_OPIMM   = 4'd7;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_OP      = 4'd8;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_MISCMEM = 4'd9;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_SYSTEM  = 4'd10;
  localparam logic [3:0] ARMLEOCPU_OPCLASS_ILLEGAL = 4'd15;

  localparam logic [6:0] ARMLEOCPU_OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_OPIMM   = 7'b0010011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_OP      = 7'b0110011;
  localparam logic [6:0] ARMLEOCPU_OPCODE_MISCMEM = 7'b0001111;
  localparam logic [6:0] ARMLEOCPU_OPCODE_SYSTEM  = 7'b1110011;

  localparam logic [31:0] ARMLEOCPU_INSTRUCTION_NOP = 32'h0000_0013;

  localparam int ARMLEOCPU_E2F_CMD_WIDTH = 3;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_NONE              = 3'd0;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_BRANCHTAKEN       = 3'd1;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_BUBBLE_EXC_START  = 3'd2;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_BUBBLE_EXC_RETURN = 3'd3;
  localparam logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] ARMLEOCPU_E2F_CMD_FLUSH             = 3'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic        exc_start;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [1:0]  exc_privilege;
  } d2e_t;

  // Bundle seen by execute after reset or when a wrong-path instruction is killed.
  function automatic d2e_t d2e_nop(input logic [31:0] pc);
    d2e_t d;
    d               = '0;
    d.instr         = ARMLEOCPU_INSTRUCTION_NOP;
    d.pc            = pc;
    d.opclass       = ARMLEOCPU_OPCLASS_OPIMM;
    return d;
  endfunction

  function automatic logic [3:0] opclass_of(input logic [6:0] opcode);
    logic [3:0] c;
    case (opcode)
      ARMLEOCPU_OPCODE_LUI:     c = ARMLEOCPU_OPCLASS_LUI;
      ARMLEOCPU_OPCODE_AUIPC:   c = ARMLEOCPU_OPCLASS_AUIPC;
      ARMLEOCPU_OPCODE_JAL:     c = ARMLEOCPU_OPCLASS_JAL;
      ARMLEOCPU_OPCODE_JALR:    c = ARMLEOCPU_OPCLASS_JALR;
      ARMLEOCPU_OPCODE_BRANCH:  c = ARMLEOCPU_OPCLASS_BRANCH;
      ARMLEOCPU_OPCODE_LOAD:    c = ARMLEOCPU_OPCLASS_LOAD;
      ARMLEOCPU_OPCODE_STORE:   c = ARMLEOCPU_OPCLASS_STORE;
      ARMLEOCPU_OPCODE_OPIMM:   c = ARMLEOCPU_OPCLASS_OPIMM;
      ARMLEOCPU_OPCODE_OP:      c = ARMLEOCPU_OPCLASS_OP;
      ARMLEOCPU_OPCODE_MISCMEM: c = ARMLEOCPU_OPCLASS_MISCMEM;
      ARMLEOCPU_OPCODE_SYSTEM:  c = ARMLEOCPU_OPCLASS_SYSTEM;
      default:                  c = ARMLEOCPU_OPCLASS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/armleocpu_decode_imm.sv
// armleocpu_decode_imm
// Purely combinational RV32I immediate generator.
// Ports:
//   instr  in  32  raw instruction
//   imm    out 32  sign-extended immediate (zero for formats without one)
module armleocpu_decode_imm
  import armleocpu_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [3:0] opclass;

  assign opclass = opclass_of(instr[6:0]);

  always_comb begin
    imm = 32'h0;
    case (opclass)
      ARMLEOCPU_OPCLASS_LUI,
      ARMLEOCPU_OPCLASS_AUIPC:
        imm = {instr[31:12], 12'b0};
      ARMLEOCPU_OPCLASS_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      ARMLEOCPU_OPCLASS_JALR,
      ARMLEOCPU_OPCLASS_LOAD,
      ARMLEOCPU_OPCLASS_OPIMM:
        imm = {{20{instr[31]}}, instr[31:20]};
      ARMLEOCPU_OPCLASS_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ARMLEOCPU_OPCLASS_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:
        imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/armleocpu_decode.sv
// armleocpu_decode
// Decode stage between fetch and execute. Registers the fetch outputs, decodes
// RV32I fields, builds the immediate and flags illegal encodings. Register-file
// read addresses are issued one cycle ahead so synchronous read data lines up
// with the d2e outputs. The execute->fetch control path passes straight through.
//
// Optional feature: define ARMLEOCPU_DECODE_M_EXT_EN to accept OP encodings with
// funct7=0000001 (M extension); otherwise they are flagged illegal.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   f2e_*                             instruction/pc/exception from fetch
//   e2f_*                             control back to fetch (= x2d_*)
//   x2d_*                             ready/command/targets from execute
//   rs1_addr, rs2_addr, rs_read       register-file read port
//   d2e_*                             registered decoded instruction to execute
module armleocpu_decode
  import armleocpu_decode_pkg::*;
#(
  parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
  input  logic                               clk,
  input  logic                               rst_n,

  input  logic [31:0]                        f2e_instr,
  input  logic [31:0]                        f2e_pc,
  input  logic                               f2e_exc_start,
  input  logic [31:0]                        f2e_epc,
  input  logic [31:0]                        f2e_cause,
  input  logic [1:0]                         f2e_exc_privilege,

  output logic                               e2f_ready,
  output logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] e2f_cmd,
  output logic [31:0]                        e2f_bubble_exc_start_target,
  output logic [31:0]                        e2f_bubble_exc_return_target,
  output logic [31:0]                        e2f_branchtarget,

  input  logic                               x2d_ready,
  input  logic [ARMLEOCPU_E2F_CMD_WIDTH-1:0] x2d_cmd,
  input  logic [31:0]                        x2d_bubble_exc_start_target,
  input  logic [31:0]                        x2d_bubble_exc_return_target,
  input  logic [31:0]                        x2d_branchtarget,

  output logic [4:0]                         rs1_addr,
  output logic [4:0]                         rs2_addr,
  output logic                               rs_read,

  output logic [31:0]                        d2e_instr,
  output logic [31:0]                        d2e_pc,
  output logic [3:0]                         d2e_opclass,
  output logic [4:0]                         d2e_rd,
  output logic [4:0]                         d2e_rs1,
  output logic [4:0]                         d2e_rs2,
  output logic [2:0]                         d2e_funct3,
  output logic [6:0]                         d2e_funct7,
  output logic [31:0]                        d2e_imm,
  output logic                               d2e_illegal,
  output logic                               d2e_exc_start,
  output logic [31:0]                        d2e_epc,
  output logic [31:0]                        d2e_cause,
  output logic [1:0]                         d2e_exc_privilege
);

`ifdef ARMLEOCPU_DECODE_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  d2e_t       d2e_q;
  d2e_t       decoded;
  logic [3:0] opclass;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm;
  logic       bad_encoding;

  assign e2f_ready                    = x2d_ready;
  assign e2f_cmd                      = x2d_cmd;
  assign e2f_bubble_exc_start_target  = x2d_bubble_exc_start_target;
  assign e2f_bubble_exc_return_target = x2d_bubble_exc_return_target;
  assign e2f_branchtarget             = x2d_branchtarget;

  // While stalled the held instruction's registers are re-read so that the
  // synchronous regfile keeps presenting its operands.
  assign rs_read  = 1'b1;
  assign rs1_addr = x2d_ready ? f2e_instr[19:15] : d2e_q.rs1;
  assign rs2_addr = x2d_ready ? f2e_instr[24:20] : d2e_q.rs2;

  assign opclass = opclass_of(f2e_instr[6:0]);
  assign funct3  = f2e_instr[14:12];
  assign funct7  = f2e_instr[31:25];

  armleocpu_decode_imm u_imm (
    .instr (f2e_instr),
    .imm   (imm)
  );

  always_comb begin
    bad_encoding = (f2e_instr[1:0] != 2'b11);
    case (opclass)
      ARMLEOCPU_OPCLASS_ILLEGAL: bad_encoding = 1'b1;
      ARMLEOCPU_OPCLASS_JALR:    if (funct3 != 3'd0) bad_encoding = 1'b1;
      ARMLEOCPU_OPCLASS_BRANCH:  if (funct3 == 3'd2 || funct3 == 3'd3) bad_encoding = 1'b1;
      ARMLEOCPU_OPCLASS_LOAD:    if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) bad_encoding = 1'b1;
      ARMLEOCPU_OPCLASS_STORE:   if (funct3 > 3'd2) bad_encoding = 1'b1;
      ARMLEOCPU_OPCLASS_OPIMM: begin
        // Only shift-immediates use the funct7 field; srai is the one alternate form.
        if (funct3 == 3'd1 && funct7 != 7'b0000000)
          bad_encoding = 1'b1;
        if (funct3 == 3'd5 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          bad_encoding = 1'b1;
      end
      ARMLEOCPU_OPCLASS_OP: begin
        if (funct7 == 7'b0100000) begin
          if (funct3 != 3'd0 && funct3 != 3'd5) bad_encoding = 1'b1;
        end else if (funct7 == 7'b0000001) begin
          if (!M_EXT) bad_encoding = 1'b1;
        end else if (funct7 != 7'b0000000) begin
          bad_encoding = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A fetch exception takes precedence, so it is never also reported as illegal.
  always_comb begin
    decoded               = '0;
    decoded.instr         = f2e_instr;
    decoded.pc            = f2e_pc;
    decoded.opclass       = opclass;
    decoded.rd            = f2e_instr[11:7];
    decoded.rs1           = f2e_instr[19:15];
    decoded.rs2           = f2e_instr[24:20];
    decoded.funct3        = funct3;
    decoded.funct7        = funct7;
    decoded.imm           = imm;
    decoded.illegal       = bad_encoding && !f2e_exc_start;
    decoded.exc_start     = f2e_exc_start;
    decoded.epc           = f2e_epc;
    decoded.cause         = f2e_cause;
    decoded.exc_privilege = f2e_exc_privilege;
  end

  // Any execute command redirects the pipe, so the instruction fetched this
  // cycle is wrong-path and is replaced by a NOP.
  always_ff @(posedge clk) begin
    if (!rst_n)
      d2e_q <= d2e_nop(NOP_PC);
    else if (x2d_ready) begin
      if (x2d_cmd != ARMLEOCPU_E2F_CMD_NONE)
        d2e_q <= d2e_nop(NOP_PC);
      else
        d2e_q <= decoded;
    end
  end

  assign d2e_instr         = d2e_q.instr;
  assign d2e_pc            = d2e_q.pc;
  assign d2e_opclass       = d2e_q.opclass;
  assign d2e_rd            = d2e_q.rd;
  assign d2e_rs1           = d2e_q.rs1;
  assign d2e_rs2           = d2e_q.rs2;
  assign d2e_funct3        = d2e_q.funct3;
  assign d2e_funct7        = d2e_q.funct7;
  assign d2e_imm           = d2e_q.imm;
  assign d2e_illegal       = d2e_q.illegal;
  assign d2e_exc_start     = d2e_q.exc_start;
  assign d2e_epc           = d2e_q.epc;
  assign d2e_cause         = d2e_q.cause;
  assign d2e_exc_privilege = d2e_q.exc_privilege;

endmodule

// File: tb/tb_armleocpu_decode.sv
// tb_armleocpu_decode
// Scoreboard bench for armleocpu_decode: each stimulus cycle pushes the expected
// d2e state into a queue, a monitor pops and compares one cycle later.
// Combinational outputs (passthrough, regfile addresses) are checked in place.
module tb_armleocpu_decode;
  import armleocpu_decode_pkg::*;

  localparam int CW = ARMLEOCPU_E2F_CMD_WIDTH;

  typedef struct {
    bit          rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    bit          exc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [1:0]  priv;
    bit          ready;
    logic [CW-1:0] cmd;
    logic [31:0] tgt_start;
    logic [31:0] tgt_return;
    logic [31:0] tgt_branch;
  } stim_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic [3:0]  opclass;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal, exc_start;
    logic [31:0] epc, cause;
    logic [1:0]  priv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] f2e_instr = 32'h13, f2e_pc = 0, f2e_epc = 0, f2e_cause = 0;
  logic f2e_exc_start = 1'b0;
  logic [1:0] f2e_exc_privilege = 2'd0;
  logic x2d_ready = 1'b0;
  logic [CW-1:0] x2d_cmd = '0;
  logic [31:0] x2d_bubble_exc_start_target = 0, x2d_bubble_exc_return_target = 0, x2d_branchtarget = 0;
  logic e2f_ready, rs_read;
  logic [CW-1:0] e2f_cmd;
  logic [31:0] e2f_bubble_exc_start_target, e2f_bubble_exc_return_target, e2f_branchtarget;
  logic [4:0] rs1_addr, rs2_addr, d2e_rd, d2e_rs1, d2e_rs2;
  logic [31:0] d2e_instr, d2e_pc, d2e_imm, d2e_epc, d2e_cause;
  logic [3:0] d2e_opclass;
  logic [2:0] d2e_funct3;
  logic [6:0] d2e_funct7;
  logic d2e_illegal, d2e_exc_start;
  logic [1:0] d2e_exc_privilege;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit known = 0;

  always #5 clk = ~clk;

  armleocpu_decode #(.NOP_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .f2e_instr(f2e_instr), .f2e_pc(f2e_pc), .f2e_exc_start(f2e_exc_start),
    .f2e_epc(f2e_epc), .f2e_cause(f2e_cause), .f2e_exc_privilege(f2e_exc_privilege),
    .e2f_ready(e2f_ready), .e2f_cmd(e2f_cmd),
    .e2f_bubble_exc_start_target(e2f_bubble_exc_start_target),
    .e2f_bubble_exc_return_target(e2f_bubble_exc_return_target),
    .e2f_branchtarget(e2f_branchtarget),
    .x2d_ready(x2d_ready), .x2d_cmd(x2d_cmd),
    .x2d_bubble_exc_start_target(x2d_bubble_exc_start_target),
    .x2d_bubble_exc_return_target(x2d_bubble_exc_return_target),
    .x2d_branchtarget(x2d_branchtarget),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs_read(rs_read),
    .d2e_instr(d2e_instr), .d2e_pc(d2e_pc), .d2e_opclass(d2e_opclass),
    .d2e_rd(d2e_rd), .d2e_rs1(d2e_rs1), .d2e_rs2(d2e_rs2),
    .d2e_funct3(d2e_funct3), .d2e_funct7(d2e_funct7), .d2e_imm(d2e_imm),
    .d2e_illegal(d2e_illegal), .d2e_exc_start(d2e_exc_start), .d2e_epc(d2e_epc),
    .d2e_cause(d2e_cause), .d2e_exc_privilege(d2e_exc_privilege)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t nop_state();
    exp_t e;
    e = '{instr: 32'h0000_0013, pc: 32'h0, opclass: ARMLEOCPU_OPCLASS_OPIMM,
          rd: 0, rs1: 0, rs2: 0, funct3: 0, funct7: 0, imm: 0,
          illegal: 0, exc_start: 0, epc: 0, cause: 0, priv: 0};
    return e;
  endfunction

  // Reference decoder: immediates are rebuilt with integer arithmetic and
  // legality from allowed-value sets.
  function automatic exp_t model_decode(input stim_t s);
    exp_t e;
    logic [31:0] i;
    int f3, f7, v;
    bit ill;
    i  = s.instr;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    e.instr = i; e.pc = s.pc;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.funct3 = i[14:12]; e.funct7 = i[31:25];
    e.exc_start = s.exc; e.epc = s.epc; e.cause = s.cause; e.priv = s.priv;
    e.imm = 0;
    ill = 0;
    case (i[6:0])
      7'b0110111: begin e.opclass = ARMLEOCPU_OPCLASS_LUI;   e.imm = i & 32'hFFFF_F000; end
      7'b0010111: begin e.opclass = ARMLEOCPU_OPCLASS_AUIPC; e.imm = i & 32'hFFFF_F000; end
      7'b1101111: begin
        e.opclass = ARMLEOCPU_OPCLASS_JAL;
        v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        e.imm = v;
      end
      7'b1100111: begin
        e.opclass = ARMLEOCPU_OPCLASS_JALR;
        v = int'(i[31:20]); if (v >= 2048) v -= 4096; e.imm = v;
        ill = (f3 != 0);
      end
      7'b1100011: begin
        e.opclass = ARMLEOCPU_OPCLASS_BRANCH;
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        e.imm = v;
        ill = (f3 inside {2, 3});
      end
      7'b0000011: begin
        e.opclass = ARMLEOCPU_OPCLASS_LOAD;
        v = int'(i[31:20]); if (v >= 2048) v -= 4096; e.imm = v;
        ill = !(f3 inside {0, 1, 2, 4, 5});
      end
      7'b0100011: begin
        e.opclass = ARMLEOCPU_OPCLASS_STORE;
        v = int'(i[31:25]) * 32 + int'(i[11:7]); if (v >= 2048) v -= 4096; e.imm = v;
        ill = (f3 > 2);
      end
      7'b0010011: begin
        e.opclass = ARMLEOCPU_OPCLASS_OPIMM;
        v = int'(i[31:20]); if (v >= 2048) v -= 4096; e.imm = v;
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) ill = !(f7 inside {0, 32});
      end
      7'b0110011: begin
        e.opclass = ARMLEOCPU_OPCLASS_OP;
        if (f7 == 0)       ill = 0;
        else if (f7 == 32) ill = !(f3 inside {0, 5});
`ifdef ARMLEOCPU_DECODE_M_EXT_EN
        else if (f7 == 1)  ill = 0;
`endif
        else               ill = 1;
      end
      7'b0001111: e.opclass = ARMLEOCPU_OPCLASS_MISCMEM;
      7'b1110011: e.opclass = ARMLEOCPU_OPCLASS_SYSTEM;
      default: begin e.opclass = ARMLEOCPU_OPCLASS_ILLEGAL; ill = 1; end
    endcase
    if (i[1:0] != 2'b11) ill = 1;
    e.illegal = ill && !s.exc;
    return e;
  endfunction

  function automatic exp_t model_next(input exp_t c, input stim_t s);
    if (!s.rst_n) return nop_state();
    if (!s.ready) return c;
    if (s.cmd != ARMLEOCPU_E2F_CMD_NONE) return nop_state();
    return model_decode(s);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    logic [6:0] f7s [4] = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1010101};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 7) begin
      r[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 2) == 0) r[31:25] = f7s[$urandom_range(0, 3)];
    end
    return r;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 99) >= 3);
    s.instr = rand_instr();
    s.pc = $urandom & 32'hFFFF_FFFC;
    s.exc = ($urandom_range(0, 9) == 0);
    s.epc = $urandom; s.cause = $urandom; s.priv = 2'($urandom_range(0, 3));
    s.ready = ($urandom_range(0, 3) != 0);
    s.cmd = ($urandom_range(0, 9) < 7) ? ARMLEOCPU_E2F_CMD_NONE : CW'($urandom_range(1, 4));
    s.tgt_start = $urandom; s.tgt_return = $urandom; s.tgt_branch = $urandom;
    return s;
  endfunction

  // Drives one cycle of inputs, checks the zero-latency outputs against the
  // currently held state, and queues the state expected after the next edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    rst_n = s.rst_n; f2e_instr = s.instr; f2e_pc = s.pc; f2e_exc_start = s.exc;
    f2e_epc = s.epc; f2e_cause = s.cause; f2e_exc_privilege = s.priv;
    x2d_ready = s.ready; x2d_cmd = s.cmd;
    x2d_bubble_exc_start_target = s.tgt_start;
    x2d_bubble_exc_return_target = s.tgt_return;
    x2d_branchtarget = s.tgt_branch;
    #1;
    checkOutput("e2f_ready", 32'(e2f_ready), 32'(s.ready));
    checkOutput("e2f_cmd", 32'(e2f_cmd), 32'(s.cmd));
    checkOutput("e2f_branchtarget", e2f_branchtarget, s.tgt_branch);
    checkOutput("e2f_exc_start_target", e2f_bubble_exc_start_target, s.tgt_start);
    checkOutput("e2f_exc_return_target", e2f_bubble_exc_return_target, s.tgt_return);
    checkOutput("rs_read", 32'(rs_read), 32'd1);
    if (s.ready) begin
      checkOutput("rs1_addr", 32'(rs1_addr), 32'(s.instr[19:15]));
      checkOutput("rs2_addr", 32'(rs2_addr), 32'(s.instr[24:20]));
    end else if (known) begin
      checkOutput("rs1_addr_held", 32'(rs1_addr), 32'(cur.rs1));
      checkOutput("rs2_addr_held", 32'(rs2_addr), 32'(cur.rs2));
    end
    cur = model_next(cur, s);
    if (!s.rst_n) known = 1;
    if (known) exp_q.push_back(cur);
  endtask

  // Monitor: the DUT presents a new d2e state after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("d2e_instr", d2e_instr, e.instr);
        checkOutput("d2e_pc", d2e_pc, e.pc);
        checkOutput("d2e_opclass", 32'(d2e_opclass), 32'(e.opclass));
        checkOutput("d2e_rd", 32'(d2e_rd), 32'(e.rd));
        checkOutput("d2e_rs1", 32'(d2e_rs1), 32'(e.rs1));
        checkOutput("d2e_rs2", 32'(d2e_rs2), 32'(e.rs2));
        checkOutput("d2e_funct3", 32'(d2e_funct3), 32'(e.funct3));
        checkOutput("d2e_funct7", 32'(d2e_funct7), 32'(e.funct7));
        checkOutput("d2e_imm", d2e_imm, e.imm);
        checkOutput("d2e_illegal", 32'(d2e_illegal), 32'(e.illegal));
        checkOutput("d2e_exc_start", 32'(d2e_exc_start), 32'(e.exc_start));
        checkOutput("d2e_epc", d2e_epc, e.epc);
        checkOutput("d2e_cause", d2e_cause, e.cause);
        checkOutput("d2e_exc_privilege", 32'(d2e_exc_privilege), 32'(e.priv));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    cur = nop_state();
    // Reset for two cycles.
    s = rand_stim(); s.rst_n = 0; s.ready = 0;
    applyStimulus(s);
    applyStimulus(s);
    // addi x1, x2, -1 flowing through.
    s = rand_stim(); s.rst_n = 1; s.ready = 1; s.cmd = ARMLEOCPU_E2F_CMD_NONE; s.exc = 0;
    s.instr = 32'hFFF1_0093; s.pc = 32'h2000;
    applyStimulus(s);
    // Three stall cycles with fetch changing, then release.
    for (int k = 0; k < 3; k++) begin
      s = rand_stim(); s.rst_n = 1; s.ready = 0;
      applyStimulus(s);
    end
    s = rand_stim(); s.rst_n = 1; s.ready = 1; s.cmd = ARMLEOCPU_E2F_CMD_NONE;
    applyStimulus(s);
    // Branch redirect kills the wrong-path instruction.
    s = rand_stim(); s.rst_n = 1; s.ready = 1; s.cmd = ARMLEOCPU_E2F_CMD_BRANCHTAKEN;
    s.tgt_branch = 32'h3000;
    applyStimulus(s);
    // mul, all-zero word, and a fetch exception carrying a NOP.
    s = rand_stim(); s.rst_n = 1; s.ready = 1; s.cmd = ARMLEOCPU_E2F_CMD_NONE; s.exc = 0;
    s.instr = 32'h0220_8033;
    applyStimulus(s);
    s.instr = 32'h0000_0000;
    applyStimulus(s);
    s.instr = 32'h0000_0013; s.exc = 1; s.cause = 1; s.epc = 32'h2004;
    applyStimulus(s);
    // Stall asserted together with reset: reset must win.
    s = rand_stim(); s.rst_n = 0; s.ready = 0;
    applyStimulus(s);
    for (int k = 0; k < 400; k++) begin
      s = rand_stim();
      applyStimulus(s);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
